// File: rtl/systolic_skew_feeder_if.sv
// Column stream into the skew feeder: valid/ready handshake carrying one
// activation column per beat plus an end-of-burst marker.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] in_data [ROWS];

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews incoming columns into the diagonal wavefront for the systolic array.
// Optional macro SKEW_FEEDER_ZERO_PAD_EN: stages carrying en=0 present zero data.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 10,
    parameter int CNT_W      = $clog2(ROWS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_skew_feeder_if.slave stream,
    output logic [ROWS-1:0]       en_left,
    output logic [DATA_WIDTH-1:0] data_left [ROWS],
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready;
    logic             accept;

    // No backpressure from the array, so only a draining burst blocks input.
    assign ready           = (state_q != DRAIN);
    assign accept          = stream.in_valid && ready;
    assign stream.in_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (stream.in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(ROWS - 1);
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                busy = 1'b1;
                if (accept && stream.in_last) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(ROWS - 1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // The counter hits zero exactly when the last beat sits on the bottom row.
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane i is i+1 stages deep; lanes keep shifting in every state so holes flush out.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic                  en_q   [i+1];
        logic [DATA_WIDTH-1:0] data_q [i+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    en_q[k] <= 1'b0;
                end
            end else begin
                en_q[0] <= accept;
                for (int k = 1; k <= i; k++) begin
                    en_q[k] <= en_q[k-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
`ifdef SKEW_FEEDER_ZERO_PAD_EN
                data_q[0] <= accept ? stream.in_data[i] : '0;
                for (int k = 1; k <= i; k++) begin
                    data_q[k] <= en_q[k-1] ? data_q[k-1] : '0;
                end
`else
                if (accept) begin
                    data_q[0] <= stream.in_data[i];
                end
                for (int k = 1; k <= i; k++) begin
                    if (en_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
`endif
            end
        end

        assign en_left[i]   = en_q[i];
        assign data_left[i] = data_q[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: wavefront timing, holes, drain
// blocking, mid-burst reset and bubble data in either build.
module tb_systolic_skew_feeder;

    localparam int DW   = 32;
    localparam int ROWS = 10;
`ifdef SKEW_FEEDER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] en_left;
    logic [DW-1:0]   data_left [ROWS];
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .ROWS(ROWS)) bus ();

    systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stream    (bus),
        .en_left   (en_left),
        .data_left (data_left),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int cycle,
                               input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s @cycle %0d observed=%0d expected=%0d", tag, cycle, observed, expected);
        end
    endtask

    // Drives one cycle's column just after the edge, then waits to mid-cycle for checking.
    task automatic applyStimulus(input logic valid, input logic last, input int base);
        @(posedge clk);
        #1;
        bus.in_valid = valid;
        bus.in_last  = last;
        for (int i = 0; i < ROWS; i++) begin
            bus.in_data[i] = 32'(base + i);
        end
        @(negedge clk);
    endtask

    task automatic runSingle(input string name);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput({name, " ready"}, 0, 32'(bus.in_ready), 32'd1);
        checkOutput({name, " en_left"}, 0, 32'(en_left), 32'd0);
        for (int c = 1; c <= 11; c++) begin
            applyStimulus(1'b0, 1'b0, 0);
            checkOutput({name, " en_left"}, c, 32'(en_left),
                        (c <= 10) ? (32'd1 << (c - 1)) : 32'd0);
            if (c <= 10) begin
                checkOutput({name, " data"}, c, data_left[c-1], 32'(c));
            end
            checkOutput({name, " done"}, c, 32'(done), 32'(c == 10));
            checkOutput({name, " busy"}, c, 32'(busy), 32'(c <= 10));
        end
        checkOutput({name, " row9 bubble"}, 11, data_left[9], PAD ? 32'd0 : 32'd10);
        checkOutput({name, " row0 bubble"}, 11, data_left[0], PAD ? 32'd0 : 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            bus.in_data[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset en_left", 0, 32'(en_left), 32'd0);
        checkOutput("reset busy", 0, 32'(busy), 32'd0);
        checkOutput("reset done", 0, 32'(done), 32'd0);
        checkOutput("reset ready", 0, 32'(bus.in_ready), 32'd1);
        checkOutput("reset data9", 0, data_left[9], 32'd0);

        // Single column, last on first beat
        runSingle("single");

        // Three back-to-back columns
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("b2b ready", 0, 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("b2b ready", 1, 32'(bus.in_ready), 32'd1);
        checkOutput("b2b row0 data", 1, data_left[0], 32'd0);
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("b2b ready", 2, 32'(bus.in_ready), 32'd1);
        checkOutput("b2b row0 data", 2, data_left[0], 32'd10);
        for (int c = 3; c <= 13; c++) begin
            applyStimulus(1'b0, 1'b0, 0);
            checkOutput("b2b ready", c, 32'(bus.in_ready), 32'(c == 13));
            checkOutput("b2b done", c, 32'(done), 32'(c == 12));
            if (c >= 10 && c <= 12) begin
                checkOutput("b2b row9 en", c, 32'(en_left[9]), 32'd1);
                checkOutput("b2b row9 data", c, data_left[9], 32'(10 * (c - 10) + 9));
            end
        end
        checkOutput("b2b en_left idle", 13, 32'(en_left), 32'd0);

        // Column A, hole, column B (last)
        applyStimulus(1'b1, 1'b0, 50);
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 70);
        for (int c = 3; c <= 13; c++) begin
            applyStimulus(1'b0, 1'b0, 0);
            checkOutput("hole done", c, 32'(done), 32'(c == 12));
            if (c >= 5 && c <= 7) begin
                checkOutput("hole row4 en", c, 32'(en_left[4]), 32'(c != 6));
                checkOutput("hole row4 data", c, data_left[4],
                            (c == 5) ? 32'd54 : (c == 6) ? (PAD ? 32'd0 : 32'd54) : 32'd74);
            end
            if (c >= 10 && c <= 12) begin
                checkOutput("hole row9 en", c, 32'(en_left[9]), 32'(c != 11));
                checkOutput("hole row9 data", c, data_left[9],
                            (c == 10) ? 32'd59 : (c == 11) ? (PAD ? 32'd0 : 32'd59) : 32'd79);
            end
        end

        // in_valid held high while draining
        applyStimulus(1'b1, 1'b1, 30);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1'b1, 1'b0, 100);
            checkOutput("hold ready", c, 32'(bus.in_ready), 32'd0);
            checkOutput("hold row0 en", c, 32'(en_left[0]), 32'(c == 1));
            checkOutput("hold done", c, 32'(done), 32'(c == 10));
        end
        applyStimulus(1'b1, 1'b1, 100);
        checkOutput("hold ready", 11, 32'(bus.in_ready), 32'd1);
        checkOutput("hold done", 11, 32'(done), 32'd0);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("hold row0 en", 12, 32'(en_left[0]), 32'd1);
        checkOutput("hold row0 data", 12, data_left[0], 32'd100);
        checkOutput("hold busy", 12, 32'(busy), 32'd1);
        for (int c = 13; c <= 22; c++) begin
            applyStimulus(1'b0, 1'b0, 0);
            checkOutput("hold done2", c, 32'(done), 32'(c == 21));
        end

        // Reset in the middle of a three-column burst
        applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        checkOutput("midrst en_left", 4, 32'(en_left), 32'd0);
        checkOutput("midrst busy", 4, 32'(busy), 32'd0);
        checkOutput("midrst done", 4, 32'(done), 32'd0);
        checkOutput("midrst data0", 4, data_left[0], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst ready", 5, 32'(bus.in_ready), 32'd1);
        for (int c = 6; c <= 14; c++) begin
            applyStimulus(1'b0, 1'b0, 0);
            checkOutput("midrst done", c, 32'(done), 32'd0);
            checkOutput("midrst en_left", c, 32'(en_left), 32'd0);
        end
        runSingle("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
